// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and helpers for the ADC seven-segment display driver:
//   - state_t       : conversion FSM states
//   - digit_code_t  : 5-bit digit code, 0..F plus DASH
//   - SEG_DASH      : active-low segment pattern for a dash
//   - glyph()       : digit code -> active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [4:0] digit_code_t;

  localparam digit_code_t DASH     = 5'h10;
  localparam logic [6:0]  SEG_DASH = 7'b0111111;

  // Active-low hex glyphs; anything outside 0..F (including DASH) shows a dash.
  function automatic logic [6:0] glyph(input digit_code_t code);
    logic [6:0] segs;
    case (code)
      5'h00:   segs = 7'b1000000;
      5'h01:   segs = 7'b1111001;
      5'h02:   segs = 7'b0100100;
      5'h03:   segs = 7'b0110000;
      5'h04:   segs = 7'b0011001;
      5'h05:   segs = 7'b0010010;
      5'h06:   segs = 7'b0000010;
      5'h07:   segs = 7'b1111000;
      5'h08:   segs = 7'b0000000;
      5'h09:   segs = 7'b0010000;
      5'h0A:   segs = 7'b0001000;
      5'h0B:   segs = 7'b0000011;
      5'h0C:   segs = 7'b1000110;
      5'h0D:   segs = 7'b0100001;
      5'h0E:   segs = 7'b0000110;
      5'h0F:   segs = 7'b0001110;
      default: segs = SEG_DASH;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: 16-bit binary -> 5 BCD digits.
// One iteration per clock: add 3 to every BCD nibble >= 5, then shift
// {bcd, bin} left by one. Sixteen iterations follow a start pulse.
//   clk    in   1   system clock
//   reset  in   1   synchronous, active-high
//   start  in   1   one-cycle pulse; loads bin and clears the scratch
//   bin    in  16   value to convert, sampled on start
//   bcd    out 20   BCD result, valid after the cycle done is high
//   done   out  1   high during the final iteration cycle
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        done
);

  logic [15:0] bin_sh;
  logic [3:0]  iter_cnt;
  logic        active;

  function automatic logic [19:0] add3_all(input logic [19:0] v);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
    end
    return r;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop in the
  // block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd      <= '0;
      bin_sh   <= '0;
      iter_cnt <= '0;
      active   <= 1'b0;
    end else if (start) begin
      bcd      <= '0;
      bin_sh   <= bin;
      iter_cnt <= '0;
      active   <= 1'b1;
    end else if (active) begin
      {bcd, bin_sh} <= {add3_all(bcd), bin_sh} << 1;
      iter_cnt      <= iter_cnt + 4'd1;
      if (iter_cnt == 4'd15) active <= 1'b0;
    end
  end

  // Asserted alongside the last iteration, so the parent can leave SHIFT
  // on the same edge that produces the final BCD value.
  assign done = active && (iter_cnt == 4'd15);

endmodule

// File: rtl/adc_display_driver.sv
// -----------------------------------------------------------------------------
// adc_display_driver
// Shows a 16-bit sample on a common-anode 4-digit seven-segment display,
// either as decimal (double-dabble BCD, dashes above 9999) or as hex.
// A one-deep pending register keeps the newest sample that arrives while a
// conversion is in flight.
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high
//   value_in     in  16   sample to display
//   value_valid  in   1   one-cycle strobe, samples value_in and hex_mode
//   hex_mode     in   1   1 = hex, 0 = decimal
//   dp_en        in   1   lights the leftmost digit's decimal point (live)
//   an           out  4   digit enables, active-low, an[0] = rightmost
//   seg          out  7   segments, active-low, {g,f,e,d,c,b,a}
//   dp           out  1   decimal point, active-low
//   busy         out  1   conversion FSM not IDLE
// -----------------------------------------------------------------------------
module adc_display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  input  logic        hex_mode,
  input  logic        dp_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t      state, state_next;
  logic [15:0] cur_value;
  logic        cur_hex;
  logic [15:0] pend_value;
  logic        pend_hex;
  logic        pend_flag;
  digit_code_t digits [4];

  logic        bcd_start;
  logic        bcd_done;
  logic [19:0] bcd;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       idx;

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    bcd_start  = 1'b0;
    case (state)
      IDLE:  if (value_valid || pend_flag) state_next = LOAD;
      LOAD: begin
        if (cur_hex) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
          bcd_start  = 1'b1;
        end
      end
      SHIFT: if (bcd_done) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Capture and pending buffer. A fresh strobe in IDLE beats a stale pending
  // value; strobes during a conversion overwrite the single pending slot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_value  <= '0;
      cur_hex    <= 1'b0;
      pend_value <= '0;
      pend_hex   <= 1'b0;
      pend_flag  <= 1'b0;
    end else if (state == IDLE) begin
      if (value_valid) begin
        cur_value <= value_in;
        cur_hex   <= hex_mode;
        pend_flag <= 1'b0;
      end else if (pend_flag) begin
        cur_value <= pend_value;
        cur_hex   <= pend_hex;
        pend_flag <= 1'b0;
      end
    end else if (value_valid) begin
      pend_value <= value_in;
      pend_hex   <= hex_mode;
      pend_flag  <= 1'b1;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (bcd_start),
    .bin   (cur_value),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  // ---------------------------------------------------------------------------
  // Digit registers, all four written together in DONE.
  // ---------------------------------------------------------------------------
  // NOTE: this small register array is reset explicitly because the display
  // must read "0000" after reset; large storage arrays would normally not be.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) digits[i] <= '0;
    end else if (state == DONE) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_hex)                 digits[i] <= {1'b0, cur_value[4*i +: 4]};
        else if (bcd[19:16] != 4'd0) digits[i] <= DASH;
        else                         digits[i] <= {1'b0, bcd[4*i +: 4]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh scan, free-running and independent of the FSM. Outputs are
  // registered from the current idx, so they trail idx by one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      idx         <= 2'd0;
      an          <= 4'b1110;
      seg         <= glyph(5'h00);
      dp          <= 1'b1;
    end else begin
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= glyph(digits[idx]);
      dp  <= ~(dp_en && (idx == 2'd3));
    end
  end

endmodule

// File: tb/tb_adc_display_driver.sv
// -----------------------------------------------------------------------------
// tb_adc_display_driver
// Directed stimulus with a scoreboard: each displayed sample pushes its four
// expected glyphs; a monitor waits for busy to fall, scans one full refresh
// round and compares the glyph seen on every digit position.
// A second instance with REFRESH_DIV=2 exercises the fast scan wrap.
// -----------------------------------------------------------------------------
module tb_adc_display_driver;

  localparam int DIV = 4;

  localparam logic [6:0] G0    = 7'b1000000;
  localparam logic [6:0] G1    = 7'b1111001;
  localparam logic [6:0] G3    = 7'b0110000;
  localparam logic [6:0] G9    = 7'b0010000;
  localparam logic [6:0] GB    = 7'b0000011;
  localparam logic [6:0] GE    = 7'b0000110;
  localparam logic [6:0] GF    = 7'b0001110;
  localparam logic [6:0] GDASH = 7'b0111111;

  typedef struct {
    string            name;
    logic [3:0][6:0]  g;     // g[i] = glyph expected when an[i] is low
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        value_valid;
  logic        hex_mode;
  logic        dp_en;
  logic [3:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        dp, dp2;
  logic        busy, busy2;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  adc_display_driver #(.REFRESH_DIV(DIV)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .hex_mode    (hex_mode),
    .dp_en       (dp_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .busy        (busy)
  );

  adc_display_driver #(.REFRESH_DIV(2)) u_dut2 (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .hex_mode    (hex_mode),
    .dp_en       (dp_en),
    .an          (an2),
    .seg         (seg2),
    .dp          (dp2),
    .busy        (busy2)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expect_display(input string name, input logic [6:0] d3,
                                input logic [6:0] d2, input logic [6:0] d1,
                                input logic [6:0] d0);
    exp_t e;
    e.name = name;
    e.g    = {d3, d2, d1, d0};
    sb_q.push_back(e);
  endtask

  // Strobe sampled at the next edge (edge T); returns 1 time unit after T.
  task automatic strobe(input logic [15:0] v, input logic hex);
    value_in    = v;
    hex_mode    = hex;
    value_valid = 1'b1;
    @(posedge clk); #1;
    value_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: a falling busy marks a finished conversion. From the next
  // negedge on, seg already reflects the new digits; 4*DIV samples cover
  // every digit slot before any following conversion can complete.
  // ---------------------------------------------------------------------------
  initial begin
    logic       prev_busy;
    logic [6:0] got  [4];
    logic [3:0] seen;
    exp_t       e;
    int         slot;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !busy) begin
          seen = 4'b0000;
          for (int i = 0; i < 4; i++) got[i] = 7'h00;
          for (int s = 0; s < 4 * DIV; s++) begin
            @(negedge clk);
            case (an)
              4'b1110: slot = 0;
              4'b1101: slot = 1;
              4'b1011: slot = 2;
              4'b0111: slot = 3;
              default: slot = -1;
            endcase
            if (slot >= 0) begin
              got[slot]  = seg;
              seen[slot] = 1'b1;
            end
          end
          if (sb_q.size() == 0) begin
            check("unexpected_display_update", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_slots_seen"}, {28'd0, seen}, 32'hF);
            for (int i = 0; i < 4; i++)
              check($sformatf("%s_digit%0d", e.name, i), {25'd0, got[i]},
                    {25'd0, e.g[i]});
          end
        end
        prev_busy = busy;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lows;
    int bad;
    reset       = 1'b1;
    value_in    = '0;
    value_valid = 1'b0;
    hex_mode    = 1'b0;
    dp_en       = 1'b0;

    cycles(3);
    check("reset_an",   {28'd0, an},   32'hE);
    check("reset_seg",  {25'd0, seg},  {25'd0, G0});
    check("reset_dp",   {31'd0, dp},   32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Scan wrap straight out of reset: an steps every DIV cycles.
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("wrap_div2_an_k%0d", k), {28'd0, an2},
            {28'd0, ~(4'b0001 << ((k / 2) % 4))});
      check($sformatf("wrap_div4_an_k%0d", k), {28'd0, an},
            {28'd0, ~(4'b0001 << ((k / 4) % 4))});
    end

    // Decimal 3300 with the decimal point on: "3.300" -> digits 3,3,0,0.
    dp_en = 1'b1;
    expect_display("dec3300", G3, G3, G0, G0);
    strobe(16'h0CE4, 1'b0);
    check("dec_busy_T", {31'd0, busy}, 32'd1);
    cycles(17);
    check("dec_busy_T17", {31'd0, busy}, 32'd1);
    cycles(1);
    check("dec_busy_T18", {31'd0, busy}, 32'd0);
    cycles(2);
    lows = 0;
    for (int k = 0; k < 4 * DIV; k++) begin
      cycles(1);
      if (!dp) lows++;
      check($sformatf("dp_k%0d", k), {31'd0, dp},
            {31'd0, (an == 4'b0111) ? 1'b0 : 1'b1});
    end
    check("dp_low_count", lows, 32'd4);
    dp_en = 1'b0;
    cycles(20);

    // Hex 0xBEEF: scan shows F,E,E,B from the right.
    expect_display("hexBEEF", GB, GE, GE, GF);
    strobe(16'hBEEF, 1'b1);
    check("hex_busy_T", {31'd0, busy}, 32'd1);
    cycles(1);
    check("hex_busy_T1", {31'd0, busy}, 32'd1);
    cycles(1);
    check("hex_busy_T2", {31'd0, busy}, 32'd0);
    cycles(40);

    // Decimal overflow and upper bound.
    expect_display("dec12345", GDASH, GDASH, GDASH, GDASH);
    strobe(16'd12345, 1'b0);
    cycles(40);
    expect_display("dec9999", G9, G9, G9, G9);
    strobe(16'd9999, 1'b0);
    cycles(40);

    // Pending overwrite: 100 at T, 200 at T+3, 300 at T+5. 200 is dropped.
    expect_display("dec100", G0, G1, G0, G0);
    expect_display("dec300", G0, G3, G0, G0);
    hex_mode = 1'b0;
    lows     = 0;
    for (int c = 0; c <= 37; c++) begin
      value_valid = (c == 0) || (c == 3) || (c == 5);
      value_in    = (c == 0) ? 16'd100 : (c == 3) ? 16'd200 : 16'd300;
      @(posedge clk); #1;
      if (c <= 36 && !busy) lows++;
      if (c == 0)  check("pend_busy_T", {31'd0, busy}, 32'd1);
      if (c == 37) check("pend_busy_T37", {31'd0, busy}, 32'd0);
    end
    value_valid = 1'b0;
    check("pend_idle_gap_cycles", lows, 32'd1);
    cycles(25);

    // Reset in the middle of a conversion discards everything.
    strobe(16'd5000, 1'b0);
    cycles(7);
    reset = 1'b1;
    cycles(1);
    check("midreset_an",   {28'd0, an},   32'hE);
    check("midreset_seg",  {25'd0, seg},  {25'd0, G0});
    check("midreset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    bad   = 0;
    for (int k = 0; k < 30; k++) begin
      cycles(1);
      if (seg !== G0 || busy !== 1'b0) bad++;
    end
    check("midreset_display_stays_0000", bad, 32'd0);

    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
